// File: rtl/uart_world_loader_pkg.sv
// ============================================================================
// uart_world_loader_pkg : shared state encoding, framing bytes, error bit map
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_world_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MODE  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_UPD_X = 3'd4,
        ST_UPD_Y = 3'd5,
        ST_UPD_Z = 3'd6,
        ST_UPD_D = 3'd7
    } loader_state_t;

    localparam logic [7:0] c_sync        = 8'hA5;
    localparam logic [7:0] c_mode_full   = 8'h01;
    localparam logic [7:0] c_mode_update = 8'h02;

    localparam int c_err_csum = 0;
    localparam int c_err_ovf  = 1;
    localparam int c_err_tmo  = 2;

endpackage

`default_nettype wire

// File: rtl/loader_write_hold.sv
// ============================================================================
// loader_write_hold : one-entry write holding register with overflow detect
// Rev 1.0
// ============================================================================
`default_nettype none

module loader_write_hold #(
    parameter int X_W       = 6,
    parameter int Y_W       = 6,
    parameter int Z_W       = 4,
    parameter int DATA_BITS = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 load_in,
    input  logic                 flush_in,
    input  logic                 probe_in,
    input  logic                 ready_in,
    input  logic [X_W-1:0]       x_in,
    input  logic [Y_W-1:0]       y_in,
    input  logic [Z_W-1:0]       z_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 valid_out,
    output logic                 overflow_out,
    output logic [X_W-1:0]       x_out,
    output logic [Y_W-1:0]       y_out,
    output logic [Z_W-1:0]       z_out,
    output logic [DATA_BITS-1:0] data_out
);

    // A new byte can only be taken if the slot is empty or drains this cycle.
    assign overflow_out = probe_in && valid_out && !ready_in;

    always_ff @(posedge clk_in) begin
        if (!rst_in || flush_in) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            data_out  <= '0;
        end else if (load_in) begin
            valid_out <= 1'b1;
            x_out     <= x_in;
            y_out     <= y_in;
            z_out     <= z_in;
            data_out  <= data_in;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_world_loader.sv
// ============================================================================
// uart_world_loader : UART packet parser issuing voxel block writes to L3
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_world_loader
    import uart_world_loader_pkg::*;
#(
    parameter int LENGTH     = 64,
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 16,
    parameter int BLOCK_BITS = 5,
    parameter int TIMEOUT    = 100_000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    output logic [$clog2(LENGTH)-1:0] wr_x_out,
    output logic [$clog2(WIDTH)-1:0]  wr_y_out,
    output logic [$clog2(HEIGHT)-1:0] wr_z_out,
    output logic [BLOCK_BITS-1:0]     wr_data_out,
    output logic                      wr_valid_out,
    input  logic                      wr_ready_in,
    output logic                      loaded_out,
    output logic                      busy_out,
    output logic [2:0]                err_out
);

    localparam int X_W = $clog2(LENGTH);
    localparam int Y_W = $clog2(WIDTH);
    localparam int Z_W = $clog2(HEIGHT);
    localparam int T_W = $clog2(TIMEOUT + 1);

    loader_state_t  r_state;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [Z_W-1:0] r_z;
    logic [7:0]     r_csum;
    logic [T_W-1:0] r_idle;
    logic           r_loaded;
    logic [2:0]     r_err;

    logic w_active;
    logic w_probe;
    logic w_wr_byte;
    logic w_ovf;
    logic w_load;
    logic w_timeout;

    assign w_active  = (r_state != ST_IDLE);
    assign w_probe   = byte_valid_in && w_active;
    assign w_wr_byte = byte_valid_in && ((r_state == ST_LOAD) || (r_state == ST_UPD_D));
    assign w_load    = w_wr_byte && !w_ovf;
    assign w_timeout = w_active && !byte_valid_in && (r_idle == T_W'(TIMEOUT - 1));

    // Both LOAD and UPD_D write at the coordinates held in r_x/r_y/r_z.
    loader_write_hold #(
        .X_W       (X_W),
        .Y_W       (Y_W),
        .Z_W       (Z_W),
        .DATA_BITS (BLOCK_BITS)
    ) u_hold (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .load_in      (w_load),
        .flush_in     (w_timeout),
        .probe_in     (w_probe),
        .ready_in     (wr_ready_in),
        .x_in         (r_x),
        .y_in         (r_y),
        .z_in         (r_z),
        .data_in      (byte_in[BLOCK_BITS-1:0]),
        .valid_out    (wr_valid_out),
        .overflow_out (w_ovf),
        .x_out        (wr_x_out),
        .y_out        (wr_y_out),
        .z_out        (wr_z_out),
        .data_out     (wr_data_out)
    );

    assign loaded_out = r_loaded;
    assign err_out    = r_err;
    assign busy_out   = w_active || wr_valid_out;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_csum   <= '0;
            r_idle   <= '0;
            r_loaded <= 1'b0;
            r_err    <= '0;
        end else begin
            r_err <= '0;
            if (!w_active || byte_valid_in) begin
                r_idle <= '0;
            end else if (r_idle != T_W'(TIMEOUT)) begin
                r_idle <= r_idle + 1'b1;
            end

            if (w_timeout) begin
                r_err[c_err_tmo] <= 1'b1;
                r_state          <= ST_IDLE;
            end else if (byte_valid_in) begin
                if (w_ovf) begin
                    r_err[c_err_ovf] <= 1'b1;
                    r_state          <= ST_IDLE;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (byte_in == c_sync) r_state <= ST_MODE;
                        end
                        ST_MODE: begin
                            if (byte_in == c_mode_full) begin
                                r_state  <= ST_LOAD;
                                r_loaded <= 1'b0;
                                r_x      <= '0;
                                r_y      <= '0;
                                r_z      <= '0;
                                r_csum   <= '0;
                            end else if (byte_in == c_mode_update) begin
                                r_state <= ST_UPD_X;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                        ST_LOAD: begin
                            // Raster order: x fastest, then y, then z.
                            r_csum <= r_csum ^ byte_in;
                            r_x    <= r_x + 1'b1;
                            if (&r_x) begin
                                r_y <= r_y + 1'b1;
                                if (&r_y) begin
                                    r_z <= r_z + 1'b1;
                                    if (&r_z) r_state <= ST_CHECK;
                                end
                            end
                        end
                        ST_CHECK: begin
                            if (byte_in == r_csum) r_loaded <= 1'b1;
                            else                   r_err[c_err_csum] <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                        ST_UPD_X: begin
                            r_x     <= byte_in[X_W-1:0];
                            r_state <= ST_UPD_Y;
                        end
                        ST_UPD_Y: begin
                            r_y     <= byte_in[Y_W-1:0];
                            r_state <= ST_UPD_Z;
                        end
                        ST_UPD_Z: begin
                            r_z     <= byte_in[Z_W-1:0];
                            r_state <= ST_UPD_D;
                        end
                        ST_UPD_D: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_world_loader.sv
// ============================================================================
// tb_uart_world_loader : scoreboard bench for uart_world_loader (4x2x2 world)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_world_loader;

    typedef struct packed {
        logic [1:0] x;
        logic       y;
        logic       z;
        logic [4:0] d;
    } wr_t;

    logic       clk_in        = 1'b0;
    logic       rst_in        = 1'b0;
    logic [7:0] byte_in       = 8'h00;
    logic       byte_valid_in = 1'b0;
    logic       wr_ready_in   = 1'b1;
    logic [1:0] wr_x_out;
    logic       wr_y_out;
    logic       wr_z_out;
    logic [4:0] wr_data_out;
    logic       wr_valid_out;
    logic       loaded_out;
    logic       busy_out;
    logic [2:0] err_out;

    int  total = 0;
    int  bad   = 0;
    int  err_cnt [3] = '{0, 0, 0};
    wr_t exp_q [$];
    wr_t cur_wr;
    wr_t prev_wr;
    wr_t exp_wr;
    logic hold_prev = 1'b0;

    uart_world_loader #(
        .LENGTH     (4),
        .WIDTH      (2),
        .HEIGHT     (2),
        .BLOCK_BITS (5),
        .TIMEOUT    (50)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .byte_in       (byte_in),
        .byte_valid_in (byte_valid_in),
        .wr_x_out      (wr_x_out),
        .wr_y_out      (wr_y_out),
        .wr_z_out      (wr_z_out),
        .wr_data_out   (wr_data_out),
        .wr_valid_out  (wr_valid_out),
        .wr_ready_in   (wr_ready_in),
        .loaded_out    (loaded_out),
        .busy_out      (busy_out),
        .err_out       (err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted write, checks held writes stay put.
    always @(negedge clk_in) begin
        cur_wr = {wr_x_out, wr_y_out, wr_z_out, wr_data_out};
        if (rst_in) begin
            for (int i = 0; i < 3; i++) if (err_out[i]) err_cnt[i] <= err_cnt[i] + 1;
            if (hold_prev) chk("hold_stable", {22'd0, wr_valid_out, cur_wr}, {22'd0, 1'b1, prev_wr});
            if (wr_valid_out && wr_ready_in) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got %0h expected none", cur_wr);
                end else begin
                    exp_wr = exp_q.pop_front();
                    chk("write", {23'd0, cur_wr}, {23'd0, exp_wr});
                end
            end
            hold_prev <= wr_valid_out && !wr_ready_in;
            prev_wr   <= cur_wr;
        end else begin
            hold_prev <= 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic put(input logic [7:0] b);
        byte_in       = b;
        byte_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic expect_wr(input int x, input int y, input int z, input int d);
        wr_t e;
        e.x = x[1:0];
        e.y = y[0];
        e.z = z[0];
        e.d = d[4:0];
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            idle(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
        idle(2);
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {20'd0, wr_x_out, wr_y_out, wr_z_out, wr_data_out, wr_valid_out,
                   loaded_out, busy_out, err_out}, 32'd0);
    endtask

    // Full load of 16 bytes with the given high bits; data field is the index.
    task automatic load_world(input logic [7:0] hi, input int gap);
        for (int i = 0; i < 16; i++) begin
            expect_wr(i % 4, (i / 4) % 2, i / 8, i);
            put(hi | 8'(i));
            if (gap > 0) begin
                if (i == 3) begin
                    wr_ready_in = 1'b0;
                    idle(10);
                    wr_ready_in = 1'b1;
                    idle(gap - 11);
                end else begin
                    idle(gap - 1);
                end
            end
        end
    endtask

    initial begin
        // Reset
        idle(2);
        check_all_zero("reset_outputs");
        rst_in = 1'b1;
        idle(1);

        // 1: good full load
        put(8'hA5);
        put(8'h01);
        load_world(8'h00, 0);
        put(8'h00);
        idle(2);
        drain("t1_drain");
        chk("t1_loaded", {31'd0, loaded_out}, 1);
        chk("t1_no_err", err_cnt[0] + err_cnt[1] + err_cnt[2], 0);

        // 2: bad checksum, then single-block update
        put(8'hA5);
        put(8'h01);
        idle(1);
        chk("t2_loaded_cleared", {31'd0, loaded_out}, 0);
        load_world(8'h00, 0);
        put(8'h01);
        idle(2);
        drain("t2_drain");
        chk("t2_csum_err", err_cnt[0], 1);
        chk("t2_loaded", {31'd0, loaded_out}, 0);
        expect_wr(3, 1, 1, 8'h1F);
        put(8'hA5);
        put(8'h02);
        put(8'h03);
        put(8'h01);
        put(8'h01);
        put(8'h1F);
        drain("t2_upd_drain");
        chk("t2_upd_loaded", {31'd0, loaded_out}, 0);
        chk("t2_upd_busy", {31'd0, busy_out}, 0);

        // 3: slow bytes with a 10-cycle ready stall; high bits ignored in data
        put(8'hA5);
        put(8'h01);
        idle(19);
        load_world(8'h40, 20);
        put(8'h00);
        idle(2);
        drain("t3_drain");
        chk("t3_loaded", {31'd0, loaded_out}, 1);
        chk("t3_errs", {err_cnt[0][7:0], err_cnt[1][7:0], err_cnt[2][7:0]}, 32'h010000);

        // 4: overflow while ready held low
        wr_ready_in = 1'b0;
        put(8'hA5);
        put(8'h01);
        expect_wr(0, 0, 0, 8'h11);
        put(8'h31);
        put(8'h32);
        idle(2);
        chk("t4_ovf_err", err_cnt[1], 1);
        chk("t4_loaded", {31'd0, loaded_out}, 0);
        chk("t4_busy_pending", {31'd0, busy_out}, 1);
        wr_ready_in = 1'b1;
        drain("t4_drain");
        chk("t4_busy_idle", {31'd0, busy_out}, 0);

        // 5: inter-byte timeout
        put(8'hA5);
        put(8'h01);
        expect_wr(0, 0, 0, 7);
        expect_wr(1, 0, 0, 8);
        expect_wr(2, 0, 0, 9);
        put(8'h07);
        put(8'h08);
        put(8'h09);
        idle(60);
        chk("t5_tmo_err", err_cnt[2], 1);
        chk("t5_busy", {31'd0, busy_out}, 0);
        drain("t5_drain");
        chk("t5_loaded", {31'd0, loaded_out}, 0);

        // 6: reset during UPD_Y, then a fresh update
        put(8'hA5);
        put(8'h02);
        put(8'h01);
        rst_in = 1'b0;
        idle(1);
        check_all_zero("t6_reset_outputs");
        rst_in = 1'b1;
        idle(1);
        expect_wr(2, 0, 1, 5);
        put(8'hA5);
        put(8'h02);
        put(8'h02);
        put(8'h00);
        put(8'h01);
        put(8'h05);
        drain("t6_drain");
        chk("t6_errs", {err_cnt[0][7:0], err_cnt[1][7:0], err_cnt[2][7:0]}, 32'h010101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
